// File: rtl/mdu_ctrl_pkg.sv
// Shared pipeline definitions: ALU op codes, MDU op codes and MDU latencies.
// The multiplier/divider control and arithmetic blocks both import this package.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    // Code 0 is a deliberate no-op; code 7 is unused and also treated as a no-op.
    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage request / architectural HI-LO bus between the pipeline and the MDU.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, op, A, B, input  busy, stall, HI, LO);
    modport slave  (input  start, op, A, B, output busy, stall, HI, LO);
endinterface

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: one shared 64-bit multiplier and a magnitude divider
// with sign fix-up, so INT_MIN / -1 wraps to INT_MIN without special casing.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);
    logic        mul_sgn, div_sgn;
    logic [63:0] a_ext, b_ext;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, uq, ur;

    assign mul_sgn = (op == MDU_MULT);
    assign div_sgn = (op == MDU_DIV);

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign a_ext = mul_sgn ? {{32{a[31]}}, a} : {32'd0, a};
    assign b_ext = mul_sgn ? {{32{b[31]}}, b} : {32'd0, b};
    assign prod  = a_ext * b_ext;

    assign a_neg    = div_sgn & a[31];
    assign b_neg    = div_sgn & b[31];
    assign a_mag    = a_neg ? (32'd0 - a) : a;
    assign b_mag    = b_neg ? (32'd0 - b) : b;
    assign div_zero = (b == 32'd0);
    assign uq       = div_zero ? 32'd0 : (a_mag / b_mag);
    assign ur       = div_zero ? 32'd0 : (a_mag % b_mag);
    assign quot     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    assign rem      = a_neg ? (32'd0 - ur) : ur;

endmodule

// File: rtl/mdu_ctrl.sv
// MDU control: IDLE/BUSY FSM with a latency down-counter; results are captured at
// the start edge into pending registers and committed to HI/LO when the count expires.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  mdu
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    hilo_t       pend, pend_nxt;
    logic        pend_we, pend_we_nxt;
    logic [31:0] hi, hi_nxt, lo, lo_nxt;

    logic [63:0] prod;
    logic [31:0] quot, rem;
    logic        div_zero;

    mdu_arith u_arith (
        .op       (mdu.op),
        .a        (mdu.A),
        .b        (mdu.B),
        .prod     (prod),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend    <= '0;
            pend_we <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend    <= pend_nxt;
            pend_we <= pend_we_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_nxt    = pend;
        pend_we_nxt = pend_we;
        hi_nxt      = hi;
        lo_nxt      = lo;
        case (state)
            IDLE: begin
                if (mdu.start) begin
                    case (mdu.op)
                        MDU_MULT, MDU_MULTU: begin
                            pend_nxt    = prod;
                            pend_we_nxt = 1'b1;
                            cnt_nxt     = MUL_LAT;
                            state_nxt   = BUSY;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            // Divide by zero still occupies the unit but never commits.
                            pend_nxt    = '{hi: rem, lo: quot};
                            pend_we_nxt = ~div_zero;
                            cnt_nxt     = DIV_LAT;
                            state_nxt   = BUSY;
                        end
                        MDU_MTHI: hi_nxt = mdu.A;
                        MDU_MTLO: lo_nxt = mdu.A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = IDLE;
                    if (pend_we) begin
                        hi_nxt = pend.hi;
                        lo_nxt = pend.lo;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mdu.busy  = (state == BUSY);
    assign mdu.stall = (mdu.start & is_muldiv(mdu.op)) | mdu.busy;
    assign mdu.HI    = hi;
    assign mdu.LO    = lo;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 SHALL have port start  input  1  E-stage request strobe for an MDU operation, sampled each clk edge.
REQ-004 SHALL have port op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-005 SHALL have port A  input  32  forwarded rs operand.
REQ-006 SHALL have port B  input  32  forwarded rt operand.
REQ-007 SHALL have port busy  output  1  high while a multi-cycle operation is in flight.
REQ-008 SHALL have port stall  output  1  equals (start & op is MULT/MULTU/DIV/DIVU) | busy; used by hazard unit for MFHI/MFLO/MDU instrs in D.
REQ-009 SHALL have port HI  output  32  architectural HI register.
REQ-010 SHALL have port LO  output  32  architectural LO register.

Function
REQ-011 SHALL implement states IDLE and BUSY plus a 4-bit down-counter cnt.
REQ-012 In IDLE with start=1 and op MULT/MULTU, SHALL latch the 64-bit product into pending regs, load cnt=5, enter BUSY.
REQ-013 In IDLE with start=1 and op DIV/DIVU, SHALL latch quotient/remainder into pending regs, load cnt=10, enter BUSY.
REQ-014 busy SHALL be 1 from the cycle after the start edge for exactly the loaded cnt cycles (5 mult, 10 div).
REQ-015 In BUSY, cnt SHALL decrement each cycle; on the edge where cnt goes 1->0, SHALL commit pending to HI/LO and return to IDLE; new HI/LO visible the cycle busy falls.
REQ-016 MTHI/MTLO with start=1 in IDLE SHALL write A to HI/LO on that edge, single cycle, busy stays 0.
REQ-017 start=1 while busy=1 SHALL be ignored (no state, counter or HI/LO change); the hazard unit guarantees it never happens.
REQ-018 MULT: signed 32x32->64; HI=upper, LO=lower. MULTU: unsigned.
REQ-019 DIV: signed, quotient truncates toward zero into LO, remainder with dividend sign into HI; DIVU unsigned.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-021 Divide by zero (B=0, DIV or DIVU) SHALL still run 10 busy cycles and leave HI/LO unchanged.
REQ-022 Undefined op codes with start=1 SHALL be treated as no-op.
REQ-023 HI/LO SHALL change only per REQ-015/REQ-016; operands after the start edge SHALL not affect the result.

Reset
REQ-024 reset=0 SHALL asynchronously force state=IDLE, cnt=0, busy=0, HI=0, LO=0, pending regs=0.
REQ-025 reset asserted mid-operation SHALL abort it; HI/LO read 0 after release, no late commit.
REQ-026 First start SHALL be accepted on the first rising edge with reset=1.

Structure
REQ-027 op encodings and latency constants (MUL_LAT=5, DIV_LAT=10) SHALL live in the shared pipeline define package alongside ALUOp codes.
REQ-028 Combinational arithmetic (signed/unsigned product, quotient, remainder, zero-divisor flag) SHALL be one sub-module mdu_arith; mdu_ctrl holds FSM, counter, pending and HI/LO regs.

Verification
REQ-029 Reset then MULT A=0xFFFFFFFE(-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 MULTU A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> busy 10 cycles, HI/LO unchanged.
REQ-032 MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive cycles -> busy stays 0, HI/LO updated next cycle each.
REQ-033 DIV started, start=1 MULT pulsed at busy cycle 3, reset pulsed low at cycle 6 -> MULT ignored, busy drops asynchronously, HI=LO=0, no later commit.
